md5_msg_padder: RTL and testbench

Message-side front end for the `md5sum` core. Accepts a byte stream, packs it little-endian into a 16-word MD5 block, appends the 0x80 pad byte, zero fill and the 64-bit bit-length, then writes the block into the core over its `rdy`/`write_en`/`msg` interface. Only single-block messages are supported: 0..MAX_MSG_BYTES bytes. Sits between the byte source (UART/host FIFO) and `md5sum`.

---
 rtl/md5_msg_padder_pkg.sv | 16 +
 rtl/md5_msg_padder_if.sv | 25 ++
 rtl/md5_msg_padder.sv | 134 +++++++++++++
 tb/tb_md5_msg_padder.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/md5_msg_padder_pkg.sv
// Shared constants and FSM state type for the MD5 message padder.
package md5_pkg;

  localparam int          MD5_BLOCK_WORDS      = 16;
  localparam logic [7:0]  MD5_PAD_BYTE         = 8'h80;
  localparam int          MD5_LEN_WORD         = 14;
  localparam int          MD5_MAX_SINGLE_BYTES = 55;

  typedef enum logic [1:0] {
    ST_COLLECT  = 2'd0,
    ST_PAD      = 2'd1,
    ST_WAIT_RDY = 2'd2,
    ST_SEND     = 2'd3
  } md5_pad_state_e;

endpackage

// File: rtl/md5_msg_padder_if.sv
// Byte-stream input and md5 core write-port signals of the message padder.
interface md5_msg_padder_if;

  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_last;
  logic        in_empty;
  logic        in_ready;
  logic        md5_rdy;
  logic        md5_write_en;
  logic [31:0] md5_msg;
  logic        busy;
  logic        msg_err;

  modport slave (
    input  in_valid, in_data, in_last, in_empty, md5_rdy,
    output in_ready, md5_write_en, md5_msg, busy, msg_err
  );

  modport master (
    output in_valid, in_data, in_last, in_empty, md5_rdy,
    input  in_ready, md5_write_en, md5_msg, busy, msg_err
  );

endinterface

// File: rtl/md5_msg_padder.sv
// Packs a single-block byte message little-endian into 16 words, appends MD5
// padding and bit length, then bursts the block into the md5 core.
// Optional build macro: MD5_PAD_OVERFLOW_CHK_EN (flag and discard oversized
// messages instead of truncating them).
module md5_msg_padder
  import md5_pkg::*;
#(
  parameter int MAX_MSG_BYTES = MD5_MAX_SINGLE_BYTES
) (
  input  logic              clk,
  input  logic              rst,
  md5_msg_padder_if.slave   bus
);

  localparam logic [5:0] MAX_LEN = 6'(MAX_MSG_BYTES);
  localparam logic [3:0] LEN_WIDX = 4'(MD5_LEN_WORD);

  md5_pad_state_e state_q, state_d;
  logic [3:0]     idx_q, idx_d;
  logic           wr_en_q, wr_en_d;
  logic [31:0]    msg_q, msg_d;
  logic           err_q, err_d;
  logic [5:0]     len_q;
  logic [31:0]    buf_q [MD5_BLOCK_WORDS];

  logic           beat;
  logic           at_max;
  logic           byte_ok;
  logic           clear_blk;

  assign beat    = bus.in_valid & bus.in_ready;
  assign at_max  = (len_q == MAX_LEN);
  assign byte_ok = beat & ~bus.in_empty & ~at_max;

`ifdef MD5_PAD_OVERFLOW_CHK_EN
  logic sop_q, sop_d;
  logic ovf_now;
  logic discard;
  assign ovf_now = beat & ~bus.in_empty & at_max;
  // A message is dropped if any of its beats (including this one) overflowed.
  assign discard = (err_q & ~sop_q) | ovf_now;
`endif

  assign bus.in_ready     = ~rst & (state_q == ST_COLLECT);
  assign bus.busy         = (state_q != ST_COLLECT);
  assign bus.md5_write_en = wr_en_q;
  assign bus.md5_msg      = msg_q;
  assign bus.msg_err      = err_q;

  // FSM next-state, word-burst outputs and error flag.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    wr_en_d   = 1'b0;
    msg_d     = '0;
    err_d     = err_q;
    clear_blk = 1'b0;
`ifdef MD5_PAD_OVERFLOW_CHK_EN
    sop_d     = sop_q;
`endif
    case (state_q)
      ST_COLLECT: begin
        if (beat) begin
`ifdef MD5_PAD_OVERFLOW_CHK_EN
          if (sop_q) err_d = 1'b0;
          if (ovf_now) err_d = 1'b1;
          sop_d = bus.in_last;
          if (bus.in_last) begin
            if (discard) clear_blk = 1'b1;
            else         state_d   = ST_PAD;
          end
`else
          if (bus.in_last) state_d = ST_PAD;
`endif
        end
      end
      ST_PAD: state_d = ST_WAIT_RDY;
      ST_WAIT_RDY: begin
        if (bus.md5_rdy) begin
          state_d = ST_SEND;
          idx_d   = '0;
        end
      end
      ST_SEND: begin
        wr_en_d = 1'b1;
        msg_d   = buf_q[idx_q];
        idx_d   = idx_q + 4'd1;
        if (idx_q == 4'd15) begin
          state_d   = ST_COLLECT;
          clear_blk = 1'b1;
        end
      end
      default: state_d = ST_COLLECT;
    endcase
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_COLLECT;
      idx_q   <= '0;
      wr_en_q <= 1'b0;
      msg_q   <= '0;
      err_q   <= 1'b0;
`ifdef MD5_PAD_OVERFLOW_CHK_EN
      sop_q   <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wr_en_q <= wr_en_d;
      msg_q   <= msg_d;
      err_q   <= err_d;
`ifdef MD5_PAD_OVERFLOW_CHK_EN
      sop_q   <= sop_d;
`endif
    end
  end

  // Block buffer: byte-lane writes while collecting, pad/length insert, clear.
  always_ff @(posedge clk) begin
    if (rst || clear_blk) begin
      for (int w = 0; w < MD5_BLOCK_WORDS; w++) buf_q[w] <= '0;
      len_q <= '0;
    end else if (byte_ok) begin
      buf_q[len_q[5:2]][{len_q[1:0], 3'b000} +: 8] <= bus.in_data;
      len_q <= len_q + 6'd1;
    end else if (state_q == ST_PAD) begin
      buf_q[len_q[5:2]][{len_q[1:0], 3'b000} +: 8] <= MD5_PAD_BYTE;
      buf_q[LEN_WIDX] <= {23'd0, len_q, 3'b000};
    end
  end

endmodule

// File: tb/tb_md5_msg_padder.sv
// Directed self-checking bench for md5_msg_padder.
module tb_md5_msg_padder;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [31:0] cap_q [$];

  always #5 clk = ~clk;

  md5_msg_padder_if bus ();

  md5_msg_padder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Core-side capture: every word strobed, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.md5_write_en === 1'b1) cap_q.push_back(bus.md5_msg);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Present one beat (called at a negedge) and hold until accepted.
  task automatic send_byte(input logic [7:0] d, input logic last, input logic empty);
    int t = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    bus.in_empty = empty;
    while (bus.in_ready !== 1'b1 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) chk("beat_timeout", 32'd0, 32'd1);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_msg(input logic [7:0] m [$], input bit hold);
    for (int i = 0; i < m.size(); i++) send_byte(m[i], (i == m.size() - 1), 1'b0);
    if (!hold) begin
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
    end
  endtask

  task automatic build_block(input logic [7:0] m [$], output logic [31:0] w [16]);
    int n;
    for (int i = 0; i < 16; i++) w[i] = '0;
    for (int k = 0; k < m.size(); k++) w[k / 4][8 * (k % 4) +: 8] = m[k];
    n = m.size();
    w[n / 4][8 * (n % 4) +: 8] = 8'h80;
    w[14] = n * 8;
  endtask

  task automatic expect_block(input string tag, input logic [31:0] w [16]);
    int t = 0;
    while (cap_q.size() < 16 && t < 300) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (cap_q.size() < 16) begin
      chk({tag, "_burst_timeout"}, 32'(cap_q.size()), 32'd16);
    end else begin
      for (int i = 0; i < 16; i++) chk($sformatf("%s_w%0d", tag, i), cap_q[i], w[i]);
      for (int i = 0; i < 16; i++) void'(cap_q.pop_front());
    end
  endtask

  logic [7:0]  m [$];
  logic [7:0]  m2 [$];
  logic [31:0] w [16];
  int cnt;

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    bus.in_empty = 1'b0;
    bus.md5_rdy  = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("post_rst_wr_en", 32'(bus.md5_write_en), 32'd0);
    chk("post_rst_msg", bus.md5_msg, 32'd0);
    chk("post_rst_busy", 32'(bus.busy), 32'd0);
    chk("post_rst_err", 32'(bus.msg_err), 32'd0);

    // "hello" with first-word latency
    m = '{8'h68, 8'h65, 8'h6C, 8'h6C, 8'h6F};
    send_msg(m, 1'b0);
    cnt = 1;
    while (bus.md5_write_en !== 1'b1 && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    chk("hello_latency", 32'(cnt), 32'd4);
    for (int i = 0; i < 16; i++) w[i] = '0;
    w[0] = 32'h6C6C6568; w[1] = 32'h0000806F; w[14] = 32'h00000028;
    expect_block("hello", w);
    repeat (4) @(negedge clk);
    chk("hello_extra_words", 32'(cap_q.size()), 32'd0);
    chk("hello_in_ready_back", 32'(bus.in_ready), 32'd1);

    // 56 bytes: one past the limit
    m = {};
    for (int i = 0; i < 56; i++) m.push_back(8'h61);
    send_msg(m, 1'b0);
`ifdef MD5_PAD_OVERFLOW_CHK_EN
    repeat (30) @(negedge clk);
    chk("ovf_no_writes", 32'(cap_q.size()), 32'd0);
    chk("ovf_err", 32'(bus.msg_err), 32'd1);
    chk("ovf_busy", 32'(bus.busy), 32'd0);
`else
    for (int i = 0; i < 16; i++) w[i] = (i < 13) ? 32'h61616161 : 32'h0;
    w[13] = 32'h80616161; w[14] = 32'h000001B8;
    expect_block("trunc56", w);
    chk("trunc_err", 32'(bus.msg_err), 32'd0);
`endif

    // Zero-length message
    send_byte(8'h00, 1'b1, 1'b1);
    chk("zero_err_cleared", 32'(bus.msg_err), 32'd0);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_empty = 1'b0;
    for (int i = 0; i < 16; i++) w[i] = '0;
    w[0] = 32'h00000080;
    expect_block("zero", w);

    // Exactly 55 bytes
    m = {};
    for (int i = 0; i < 55; i++) m.push_back(8'h61);
    send_msg(m, 1'b0);
    for (int i = 0; i < 16; i++) w[i] = (i < 13) ? 32'h61616161 : 32'h0;
    w[13] = 32'h80616161; w[14] = 32'h000001B8;
    expect_block("max55", w);

    // Core not ready for 20 cycles
    bus.md5_rdy = 1'b0;
    m = '{8'h61};
    send_msg(m, 1'b0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.md5_write_en !== 1'b0 || bus.in_ready !== 1'b0 || bus.busy !== 1'b1) cnt++;
    end
    chk("hold_violations", 32'(cnt), 32'd0);
    chk("hold_no_writes", 32'(cap_q.size()), 32'd0);
    bus.md5_rdy = 1'b1;
    for (int i = 0; i < 16; i++) w[i] = '0;
    w[0] = 32'h00008061; w[14] = 32'h00000008;
    expect_block("hold", w);

    // Reset during the burst
    m = '{8'h68, 8'h65, 8'h6C, 8'h6C, 8'h6F};
    send_msg(m, 1'b0);
    cnt = 0;
    while (cap_q.size() < 7 && cnt < 100) begin
      @(negedge clk);
      #1;
      cnt++;
    end
    chk("abort_reached", 32'(cap_q.size()), 32'd7);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_wr_en", 32'(bus.md5_write_en), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    rst = 1'b0;
    cap_q.delete();
    @(negedge clk);
    m = '{8'h61, 8'h62, 8'h63};
    send_msg(m, 1'b0);
    for (int i = 0; i < 16; i++) w[i] = '0;
    w[0] = 32'h80636261; w[14] = 32'h00000018;
    expect_block("abc", w);

    // Back-to-back messages with valid held high
    m  = '{8'h78, 8'h79, 8'h7A, 8'h31, 8'h32, 8'h33};
    m2 = '{8'h70, 8'h71};
    send_msg(m, 1'b1);
    send_msg(m2, 1'b0);
    build_block(m, w);
    expect_block("b2b_first", w);
    build_block(m2, w);
    expect_block("b2b_second", w);
    repeat (4) @(negedge clk);
    chk("b2b_extra_words", 32'(cap_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
